pipe_stage_register: RTL and testbench

Parametrised, handshaked pipeline stage register with a built-in one-entry skid buffer, synchronous flush and bubble injection. It is the generic successor to the fixed IF/ID latch and is instanced between any two core stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Payload is an opaque DATA_WIDTH vector, for example {instruction, pc}. Upstream sees a registered ready, so stalls propagate backwards without a combinational path.

---
 rtl/pipe_stage_register.sv | 125 ++++++++++++
 tb/tb_pipe_stage_register.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_register.sv
// Handshaked pipeline stage register with a one-entry skid buffer, synchronous
// flush and bubble injection. All outputs are registered; ready_o never sees inputs.
module pipe_stage_register #(
  parameter int unsigned           DATA_WIDTH   = 64,
  parameter logic [DATA_WIDTH-1:0] BUBBLE_VALUE = {32'h0000_0013, 32'h0000_0000}
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  flush_i,
  output logic [1:0]            occupancy_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_main;
  logic [DATA_WIDTH-1:0] r_skid;
  logic                  r_valid;
  logic                  r_ready;
  logic [1:0]            r_occ;

  state_t                w_next_state;
  logic [DATA_WIDTH-1:0] w_main_next;
  logic [DATA_WIDTH-1:0] w_skid_next;
  logic                  w_accept;
  logic                  w_take;

  function automatic logic [1:0] occ_of(input state_t st);
    case (st)
      ST_EMPTY: occ_of = 2'd0;
      ST_ONE:   occ_of = 2'd1;
      ST_FULL:  occ_of = 2'd2;
      default:  occ_of = 2'd0;
    endcase
  endfunction

  assign w_accept = valid_i & r_ready;
  assign w_take   = r_valid & ready_i;

  // Next-state and storage update; flush overrides every transition.
  always_comb begin
    w_next_state = r_state;
    w_main_next  = r_main;
    w_skid_next  = r_skid;
    if (flush_i) begin
      w_next_state = ST_EMPTY;
      w_main_next  = BUBBLE_VALUE;
      w_skid_next  = BUBBLE_VALUE;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_next_state = ST_ONE;
            w_main_next  = data_i;
          end else begin
            w_next_state = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (w_accept && w_take) begin
            w_main_next = data_i;
          end else if (w_accept) begin
            w_next_state = ST_FULL;
            w_skid_next  = data_i;
          end else if (w_take) begin
            w_next_state = ST_EMPTY;
            w_main_next  = BUBBLE_VALUE;
          end else begin
            w_next_state = ST_ONE;
          end
        end
        ST_FULL: begin
          // The skid entry is always younger than main, so it moves up on a take.
          if (w_take) begin
            w_next_state = ST_ONE;
            w_main_next  = r_skid;
            w_skid_next  = BUBBLE_VALUE;
          end else begin
            w_next_state = ST_FULL;
          end
        end
        default: begin
          w_next_state = ST_EMPTY;
          w_main_next  = BUBBLE_VALUE;
          w_skid_next  = BUBBLE_VALUE;
        end
      endcase
    end
  end

  // State, storage and output flags, all decoded from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_EMPTY;
      r_main  <= BUBBLE_VALUE;
      r_skid  <= BUBBLE_VALUE;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
      r_occ   <= 2'd0;
    end else begin
      r_state <= w_next_state;
      r_main  <= w_main_next;
      r_skid  <= w_skid_next;
      r_valid <= (w_next_state != ST_EMPTY);
      r_ready <= (w_next_state != ST_FULL);
      r_occ   <= occ_of(w_next_state);
    end
  end

  assign valid_o     = r_valid;
  assign ready_o     = r_ready;
  assign data_o      = r_main;
  assign occupancy_o = r_occ;

endmodule

// File: tb/tb_pipe_stage_register.sv
// Directed and scoreboard tests for pipe_stage_register.
module tb_pipe_stage_register;
  localparam logic [63:0] BUB = {32'h0000_0013, 32'h0000_0000};

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid_i, ready_i, flush_i;
  logic [63:0] data_i;
  logic        ready_o, valid_o;
  logic [63:0] data_o;
  logic [1:0]  occupancy_o;

  int n_checks = 0;
  int n_errors = 0;

  pipe_stage_register dut (
    .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
    .flush_i(flush_i), .occupancy_o(occupancy_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; valid_i = 1'b0; ready_i = 1'b0; flush_i = 1'b0; data_i = 64'h0;
    @(negedge clk); @(negedge clk);
    n_checks++; if (valid_o !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %b exp 0", valid_o); end
    n_checks++; if (ready_o !== 1'b1) begin n_errors++; $display("FAIL reset_ready got %b exp 1", ready_o); end
    n_checks++; if (occupancy_o !== 2'd0) begin n_errors++; $display("FAIL reset_occ got %0d exp 0", occupancy_o); end
    n_checks++; if (data_o !== BUB) begin n_errors++; $display("FAIL reset_data got %h exp %h", data_o, BUB); end
    reset_n = 1'b1;
    tick();
    n_checks++; if (valid_o !== 1'b0) begin n_errors++; $display("FAIL post_reset_valid got %b exp 0", valid_o); end
  endtask

  task automatic test_stream();
    ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      valid_i = 1'b1; data_i = 64'(i);
      tick();
      n_checks++; if (data_o !== 64'(i) || valid_o !== 1'b1) begin
        n_errors++; $display("FAIL stream_data[%0d] got %h/%b exp %h/1", i, data_o, valid_o, 64'(i)); end
      n_checks++; if (occupancy_o !== 2'd1) begin n_errors++; $display("FAIL stream_occ[%0d] got %0d exp 1", i, occupancy_o); end
    end
    valid_i = 1'b0;
    tick();
    n_checks++; if (valid_o !== 1'b0 || data_o !== BUB) begin
      n_errors++; $display("FAIL stream_drain got %b/%h exp 0/%h", valid_o, data_o, BUB); end
  endtask

  task automatic test_stall_skid();
    valid_i = 1'b1; data_i = 64'hA; ready_i = 1'b1;
    tick();
    n_checks++; if (data_o !== 64'hA || occupancy_o !== 2'd1) begin
      n_errors++; $display("FAIL skid_first got %h/%0d exp a/1", data_o, occupancy_o); end
    ready_i = 1'b0; data_i = 64'hB;
    tick();
    n_checks++; if (occupancy_o !== 2'd2 || ready_o !== 1'b0) begin
      n_errors++; $display("FAIL skid_full got occ=%0d rdy=%b exp 2/0", occupancy_o, ready_o); end
    data_i = 64'hC;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (data_o !== 64'hA || occupancy_o !== 2'd2 || ready_o !== 1'b0) begin
        n_errors++; $display("FAIL skid_hold[%0d] got %h/%0d/%b exp a/2/0", i, data_o, occupancy_o, ready_o); end
    end
    ready_i = 1'b1;
    tick();
    n_checks++; if (data_o !== 64'hB || occupancy_o !== 2'd1 || ready_o !== 1'b1) begin
      n_errors++; $display("FAIL skid_release_b got %h/%0d/%b exp b/1/1", data_o, occupancy_o, ready_o); end
    tick();
    n_checks++; if (data_o !== 64'hC || valid_o !== 1'b1) begin
      n_errors++; $display("FAIL skid_release_c got %h/%b exp c/1", data_o, valid_o); end
    valid_i = 1'b0;
    tick();
    n_checks++; if (valid_o !== 1'b0 || occupancy_o !== 2'd0) begin
      n_errors++; $display("FAIL skid_drain got %b/%0d exp 0/0", valid_o, occupancy_o); end
  endtask

  task automatic test_flush_full();
    valid_i = 1'b1; ready_i = 1'b0; data_i = 64'h1;
    tick();
    data_i = 64'h2;
    tick();
    n_checks++; if (occupancy_o !== 2'd2) begin n_errors++; $display("FAIL flush_setup_occ got %0d exp 2", occupancy_o); end
    data_i = 64'hD; flush_i = 1'b1;
    tick();
    n_checks++; if (valid_o !== 1'b0 || data_o !== BUB || occupancy_o !== 2'd0 || ready_o !== 1'b1) begin
      n_errors++; $display("FAIL flush_full got %b/%h/%0d/%b exp 0/%h/0/1", valid_o, data_o, occupancy_o, ready_o, BUB); end
    tick();
    n_checks++; if (valid_o !== 1'b0 || occupancy_o !== 2'd0) begin
      n_errors++; $display("FAIL flush_held got %b/%0d exp 0/0", valid_o, occupancy_o); end
    flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    tick();
    n_checks++; if (valid_o !== 1'b0 || data_o !== BUB) begin
      n_errors++; $display("FAIL flush_no_d got %b/%h exp 0/%h", valid_o, data_o, BUB); end
  endtask

  task automatic test_flush_take();
    valid_i = 1'b1; data_i = 64'h55; ready_i = 1'b1;
    tick();
    valid_i = 1'b0; flush_i = 1'b1;
    n_checks++; if (valid_o !== 1'b1 || data_o !== 64'h55) begin
      n_errors++; $display("FAIL flush_take_seen got %b/%h exp 1/55", valid_o, data_o); end
    tick();
    flush_i = 1'b0;
    n_checks++; if (valid_o !== 1'b0 || occupancy_o !== 2'd0 || data_o !== BUB) begin
      n_errors++; $display("FAIL flush_take_after got %b/%0d/%h exp 0/0/%h", valid_o, occupancy_o, data_o, BUB); end
  endtask

  task automatic test_reset_midstream();
    valid_i = 1'b1; ready_i = 1'b0; data_i = 64'h7;
    tick();
    data_i = 64'h8;
    tick();
    n_checks++; if (occupancy_o !== 2'd2) begin n_errors++; $display("FAIL rst_mid_setup got %0d exp 2", occupancy_o); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1 || occupancy_o !== 2'd0 || data_o !== BUB) begin
      n_errors++; $display("FAIL rst_mid got %b/%b/%0d/%h exp 0/1/0/%h", valid_o, ready_o, occupancy_o, data_o, BUB); end
    valid_i = 1'b0; ready_i = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    n_checks++; if (valid_o !== 1'b0 || data_o !== BUB) begin
      n_errors++; $display("FAIL rst_mid_release got %b/%h exp 0/%h", valid_o, data_o, BUB); end
  endtask

  task automatic test_random();
    logic [63:0] q[$];
    logic        acc, tk;
    int unsigned seq = 32'd1000;
    for (int c = 0; c < 10000; c++) begin
      n_checks++; if (valid_o !== (q.size() != 0)) begin
        n_errors++; $display("FAIL rnd_valid @%0d got %b exp %0d", c, valid_o, q.size() != 0); end
      n_checks++; if (occupancy_o !== 2'(q.size())) begin
        n_errors++; $display("FAIL rnd_occ @%0d got %0d exp %0d", c, occupancy_o, q.size()); end
      n_checks++; if (ready_o !== (q.size() < 2)) begin
        n_errors++; $display("FAIL rnd_ready @%0d got %b exp %0d", c, ready_o, q.size() < 2); end
      n_checks++; if (data_o !== ((q.size() != 0) ? q[0] : BUB)) begin
        n_errors++; $display("FAIL rnd_data @%0d got %h exp %h", c, data_o, (q.size() != 0) ? q[0] : BUB); end
      valid_i = ($urandom_range(0, 9) < 7);
      ready_i = ($urandom_range(0, 9) < 6);
      flush_i = ($urandom_range(0, 99) < 3);
      data_i  = {32'h0, seq};
      seq++;
      acc = valid_i && (q.size() < 2);
      tk  = ready_i && (q.size() != 0);
      tick();
      if (flush_i) begin
        q.delete();
      end else begin
        if (tk) void'(q.pop_front());
        if (acc) q.push_back(data_i);
      end
    end
    valid_i = 1'b0; flush_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_skid();
    test_flush_full();
    test_flush_take();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
